concatenador_serial: RTL and testbench
======================================

Name: concatenador_serial

Overview:
- Parametrised sequential packer, successor to the two-operand 16-bit concatenator.
- Accepts IN_W-bit operands one per beat on a valid/ready input stream and concatenates NUM_OPS of them into one IN_W*NUM_OPS-bit word.
- Presents the word on a registered valid/ready output.
- Supports selectable slot order and a flush that emits a zero-padded partial word. Sits between operand producers (ALU/UART byte sources) and wide-word consumers.

Parameters:
- IN_W, 8, operand width in bits (>=1).
- NUM_OPS, 2, operands per output word (>=2).
- MSB_FIRST, 1, 1: first accepted operand occupies the most significant slot; 0: first operand occupies the least significant slot.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IN_DATA  input  IN_W  operand.
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  block can accept operand this cycle.
- FLUSH  input  1  request to emit the current partial word.
- OUT_DATA  output  IN_W*NUM_OPS  concatenated word, registered.
- OUT_VALID  output  1  OUT_DATA holds an unconsumed word.
- OUT_READY  input  1  consumer accepts word this cycle.
- OUT_COUNT  output  $clog2(NUM_OPS+1)  number of real operands in OUT_DATA: NUM_OPS for a full word, fewer for a flushed partial word.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- rst_n=0 immediately clears:
  - OUT_DATA=0, OUT_VALID=0, OUT_COUNT=0.
  - Accumulator contents and operand count = 0.
  - Pending-flush flag = 0.
- Any partial word is discarded on reset mid-operation.

Transfers:
- Input transfer = IN_VALID & IN_READY. Output transfer = OUT_VALID & OUT_READY.
- Output slot is "free" when !OUT_VALID | OUT_READY.
- IN_READY (combinational) = !flush_pend & ((count < NUM_OPS-1) | slot free).
- IN_READY never depends on IN_VALID.

Slot placement:
- The operand accepted with count=k goes to slot k.
- MSB_FIRST=1: slot k = bits [IN_W*(NUM_OPS-k)-1 : IN_W*(NUM_OPS-k-1)].
- MSB_FIRST=0: slot k = bits [IN_W*(k+1)-1 : IN_W*k].
- With NUM_OPS=2 and MSB_FIRST=1 the output equals {first, second}.

Full word:
- Accepting the operand with count=NUM_OPS-1 loads accumulator plus that operand into OUT_DATA at the same edge.
- That edge sets OUT_VALID=1 and OUT_COUNT=NUM_OPS, and returns count to 0 with the accumulator cleared to 0.
- Latency: last operand accepted at edge N -> OUT_VALID=1 after edge N.
- Back-to-back full words are sustained at one operand per cycle when OUT_READY=1.

Output register:
- Holds OUT_DATA and OUT_COUNT stable while OUT_VALID & !OUT_READY.
- An output transfer with no new load clears OUT_VALID at the next edge. OUT_DATA keeps its value.
- Simultaneous output transfer and new load: the new word replaces the old and OUT_VALID stays 1.

Flush:
- FLUSH sampled high sets flush_pend if (count > 0) or (an input transfer occurs the same cycle).
- FLUSH with count=0 and no input transfer is ignored.
- An input transfer in the FLUSH cycle is included first. If it completes the word, a normal full word is emitted and flush_pend is not set.
- While flush_pend=1 and the slot is free:
  - Load OUT_DATA = accumulator, with unfilled slots 0.
  - OUT_COUNT = count, OUT_VALID = 1.
  - Clear count, accumulator and flush_pend.
- While flush_pend=1, IN_READY=0. Partial-word boundaries are never merged.
- FLUSH asserted again while flush_pend=1 has no extra effect.

Test Plan:
- Defaults; send 0xAB, 0xCD with OUT_READY=1 -> one cycle after the second accept OUT_DATA=0xABCD, OUT_VALID=1, OUT_COUNT=2.
- MSB_FIRST=0, NUM_OPS=4; send 0x11, 0x22, 0x33, 0x44 -> OUT_DATA=0x44332211, OUT_COUNT=4.
- Defaults, OUT_READY=0; send 0x01, 0x02, then offer 0x03 -> OUT_DATA=0x0102 held. 0x03 is accepted (count 0). IN_READY=0 when 0x04 is offered while the slot is full. Raise OUT_READY -> 0x0304 follows with no operand lost.
- NUM_OPS=4, MSB_FIRST=1; send 0xAA, 0xBB, pulse FLUSH -> OUT_DATA=0xAABB0000, OUT_COUNT=2. IN_READY=0 until the flushed word is loaded. FLUSH with count=0 produces nothing.
- Defaults; FLUSH in the same cycle as accepting the second operand 0x5A after 0xA5 -> a single word 0xA55A, OUT_COUNT=2, no extra partial word.
- Continuous stream with OUT_READY=1 -> one word every NUM_OPS cycles. Drop rst_n mid-word after one operand -> all outputs 0 immediately. The next two operands 0x12, 0x34 give 0x1234.

Source files
------------

// File: rtl/concatenador_serial.sv
// concatenador_serial: packs NUM_OPS operands of IN_W bits into one word.
// Ports: clk, rst_n, IN_* operand stream, FLUSH, OUT_* registered word stream.
module concatenador_serial #(
    parameter int IN_W      = 8,
    parameter int NUM_OPS   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IN_W-1:0]          IN_DATA,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic                     FLUSH,
    output logic [IN_W*NUM_OPS-1:0]  OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(NUM_OPS+1)-1:0] OUT_COUNT
);

    localparam int OW = IN_W * NUM_OPS;
    localparam int CW = $clog2(NUM_OPS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_OPS - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_OPS);

    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          pend_q, pend_d;
    logic [OW-1:0] odata_q, odata_d;
    logic          ovalid_q, ovalid_d;
    logic [CW-1:0] ocount_q, ocount_d;

    logic          slot_free;
    logic          in_rdy;
    logic          in_fire;
    logic [OW-1:0] placed;
    logic [OW-1:0] merged;

    function automatic int slot_lo(input int k);
        return MSB_FIRST ? IN_W * (NUM_OPS - 1 - k) : IN_W * k;
    endfunction

    assign slot_free = !ovalid_q || OUT_READY;
    assign in_rdy    = !pend_q && ((count_q < LAST) || slot_free);
    assign in_fire   = IN_VALID && in_rdy;

    // Operand positioned in the slot selected by the current count.
    always_comb begin
        placed = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (count_q == CW'(k)) begin
                placed[slot_lo(k) +: IN_W] = IN_DATA;
            end
        end
    end

    assign merged = acc_q | placed;

    always_comb begin
        acc_d    = acc_q;
        count_d  = count_q;
        pend_d   = pend_q;
        odata_d  = odata_q;
        ocount_d = ocount_q;
        ovalid_d = ovalid_q && !OUT_READY;
        if (pend_q) begin
            // Input is blocked while a flush waits for the output slot.
            if (slot_free) begin
                odata_d  = acc_q;
                ocount_d = count_q;
                ovalid_d = 1'b1;
                acc_d    = '0;
                count_d  = '0;
                pend_d   = 1'b0;
            end
        end else if (in_fire) begin
            if (count_q == LAST) begin
                odata_d  = merged;
                ocount_d = FULL;
                ovalid_d = 1'b1;
                acc_d    = '0;
                count_d  = '0;
            end else begin
                acc_d   = merged;
                count_d = count_q + CW'(1);
                pend_d  = FLUSH;
            end
        end else if (FLUSH && (count_q != '0)) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ocount_q <= '0;
        end else begin
            acc_q    <= acc_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ocount_q <= ocount_d;
        end
    end

    assign IN_READY  = in_rdy;
    assign OUT_DATA  = odata_q;
    assign OUT_VALID = ovalid_q;
    assign OUT_COUNT = ocount_q;

endmodule

// File: tb/tb_concatenador_serial.sv
// tb_concatenador_serial: three configurations driven by shared stimulus,
// checked every cycle against an operand-list model plus literal cases.
module tb_concatenador_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] in_data = '0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;

    logic        r0, r1, r2, v0, v1, v2;
    logic [15:0] od0;
    logic [31:0] od1, od2;
    logic [1:0]  oc0;
    logic [2:0]  oc1, oc2;

    concatenador_serial #(.IN_W(8), .NUM_OPS(2), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(r0), .FLUSH(flush), .OUT_DATA(od0), .OUT_VALID(v0),
        .OUT_READY(out_ready), .OUT_COUNT(oc0));
    concatenador_serial #(.IN_W(8), .NUM_OPS(4), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(r1), .FLUSH(flush), .OUT_DATA(od1), .OUT_VALID(v1),
        .OUT_READY(out_ready), .OUT_COUNT(oc1));
    concatenador_serial #(.IN_W(8), .NUM_OPS(4), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(r2), .FLUSH(flush), .OUT_DATA(od2), .OUT_VALID(v2),
        .OUT_READY(out_ready), .OUT_COUNT(oc2));

    logic        d_rdy [3];
    logic        d_val [3];
    logic [31:0] d_dat [3];
    logic [31:0] d_cnt [3];
    assign d_rdy[0] = r0;
    assign d_rdy[1] = r1;
    assign d_rdy[2] = r2;
    assign d_val[0] = v0;
    assign d_val[1] = v1;
    assign d_val[2] = v2;
    assign d_dat[0] = {16'h0, od0};
    assign d_dat[1] = od1;
    assign d_dat[2] = od2;
    assign d_cnt[0] = {30'h0, oc0};
    assign d_cnt[1] = {29'h0, oc1};
    assign d_cnt[2] = {29'h0, oc2};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: operands held as a list, word assembled from the slot rules.
    int          nops [3] = '{2, 4, 4};
    bit          msb  [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  m_ops [3][4];
    int          m_cnt [3];
    bit          m_pend [3];
    bit          m_oval [3];
    logic [31:0] m_odat [3];
    int          m_ocnt [3];

    function automatic logic [31:0] m_word(input int i, input int n);
        logic [31:0] w;
        int pos;
        w = '0;
        for (int k = 0; k < n; k++) begin
            pos = msb[i] ? 8 * (nops[i] - 1 - k) : 8 * k;
            w = w | (32'(m_ops[i][k]) << pos);
        end
        return w;
    endfunction

    function automatic bit m_rdy(input int i);
        return !m_pend[i] &&
               ((m_cnt[i] < nops[i] - 1) || !m_oval[i] || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rdy_i, free, fire;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0;
                m_pend[i] = 1'b0;
                m_oval[i] = 1'b0;
                m_odat[i] = '0;
                m_ocnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                rdy_i = m_rdy(i);
                free = !m_oval[i] || out_ready;
                fire = in_valid && rdy_i;
                if (m_oval[i] && out_ready) m_oval[i] = 1'b0;
                if (m_pend[i]) begin
                    if (free) begin
                        m_odat[i] = m_word(i, m_cnt[i]);
                        m_ocnt[i] = m_cnt[i];
                        m_oval[i] = 1'b1;
                        m_cnt[i] = 0;
                        m_pend[i] = 1'b0;
                    end
                end else if (fire) begin
                    m_ops[i][m_cnt[i]] = in_data;
                    m_cnt[i]++;
                    if (m_cnt[i] == nops[i]) begin
                        m_odat[i] = m_word(i, nops[i]);
                        m_ocnt[i] = nops[i];
                        m_oval[i] = 1'b1;
                        m_cnt[i] = 0;
                    end else if (flush) begin
                        m_pend[i] = 1'b1;
                    end
                end else if (flush && m_cnt[i] > 0) begin
                    m_pend[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d in_ready", i), 32'(d_rdy[i]), 32'(m_rdy(i)));
            chk($sformatf("u%0d out_valid", i), 32'(d_val[i]), 32'(m_oval[i]));
            chk($sformatf("u%0d out_count", i), d_cnt[i], 32'(m_ocnt[i]));
            chk($sformatf("u%0d out_data", i), d_dat[i], m_odat[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        chk("reset od0", 32'(od0), 32'h0);
        chk("reset v0", 32'(v0), 32'h0);
        chk("reset oc0", 32'(oc0), 32'h0);

        // Streaming 11,22,33,44 with the consumer always ready
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        chk("u0 word1122", 32'(od0), 32'h1122);
        chk("u0 cnt2", 32'(oc0), 32'd2);
        chk("u0 valid", 32'(v0), 32'd1);
        in_data = 8'h33; tick();
        in_data = 8'h44; tick();
        in_valid = 1'b0;
        chk("u0 word3344", 32'(od0), 32'h3344);
        chk("u1 lsb-first", od1, 32'h44332211);
        chk("u1 cnt4", 32'(oc1), 32'd4);
        chk("u2 msb-first", od2, 32'h11223344);

        // Backpressure: held word, one operand queued, none lost
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        in_data = 8'h03; tick();
        chk("held 0102", 32'(od0), 32'h0102);
        chk("held valid", 32'(v0), 32'd1);
        in_data = 8'h04;
        #1;
        chk("stall ready", 32'(r0), 32'd0);
        tick();
        chk("still 0102", 32'(od0), 32'h0102);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("next 0304", 32'(od0), 32'h0304);
        chk("next cnt", 32'(oc0), 32'd2);

        // Partial flush on NUM_OPS=4
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA; tick();
        in_data = 8'hBB; tick();
        in_valid = 1'b0;
        flush = 1'b1; tick();
        flush = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hCC;
        #1;
        chk("pend ready", 32'(r2), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("u2 partial", od2, 32'hAABB0000);
        chk("u2 pcnt", 32'(oc2), 32'd2);
        chk("u1 partial", od1, 32'h0000BBAA);
        flush = 1'b1; tick();
        flush = 1'b0; tick();
        chk("empty flush", 32'(v2), 32'd0);

        // Flush coinciding with the completing operand
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5; tick();
        in_data = 8'h5A;
        flush = 1'b1; tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("u0 a55a", 32'(od0), 32'hA55A);
        chk("u0 a55a cnt", 32'(oc0), 32'd2);
        tick();
        tick();
        chk("no extra word", 32'(v0), 32'd0);

        // Reset mid-word discards the partial operand
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h55; tick();
        in_data = 8'h66; tick();
        in_data = 8'h77; tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async od0", 32'(od0), 32'h0);
        chk("async v0", 32'(v0), 32'h0);
        chk("async oc0", 32'(oc0), 32'h0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h12; tick();
        in_data = 8'h34; tick();
        in_valid = 1'b0;
        chk("after reset 1234", 32'(od0), 32'h1234);

        // Randomised traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            flush = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
